result_drain_scheduler: RTL

//  Sequences the drain of the systolic array's results into the result shift lane.

---
 rtl/mm_pkg.sv | 16 +
 rtl/result_credit_counter.sv | 41 ++++
 rtl/result_drain_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared types for the matrix-multiply result path.
// Drain FSM states and drain geometry helper.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STALL,
        FLUSH
    } drain_state_e;

    function automatic int beats_per_drain(int w, int h, int counter);
        return (w * h) / counter;
    endfunction

endpackage

// File: rtl/result_credit_counter.sv
// Free-slot credit counter for the result shift lane.
// Starts full, one credit per lane beat slot.
module result_credit_counter
    import mm_pkg::*;
#(
    parameter int SLOTS = 16,
    parameter int CW    = $clog2(SLOTS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          take_i,
    input  logic          give_i,
    output logic [CW-1:0] count_o,
    output logic          avail_o
);

    logic [CW-1:0] r_count;

    // Take on beat start, give on lane accept; saturate at both ends
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= CW'(SLOTS);
        end else begin
            case ({take_i, give_i})
                2'b10: if (r_count != '0) r_count <= r_count - 1'b1;
                2'b01: if (r_count != CW'(SLOTS)) r_count <= r_count + 1'b1;
                default: ;
            endcase
        end
    end

    // A lane accept with every slot already free means the lane is broken
    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset)
        !(give_i && (r_count == CW'(SLOTS)))
    );

    assign count_o = r_count;
    assign avail_o = (r_count != '0);

endmodule

// File: rtl/result_drain_scheduler.sv
// Drains systolic array results into the shift lane, one element per cycle.
// Beats only start when the lane has a free slot.
module result_drain_scheduler
    import mm_pkg::*;
#(
    parameter int ARRAY_WIDTH  = 16,
    parameter int ARRAY_HEIGHT = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int BUS_WIDTH    = 256,
    parameter int SLOTS        = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [ARRAY_WIDTH-1:0]          array_reset_n_o,
    output logic [$clog2(ARRAY_HEIGHT)-1:0] row_sel_o,
    input  logic                            accepted_i,
    output logic [$clog2(SLOTS+1)-1:0]      credits_o
);

    localparam int COUNTER = BUS_WIDTH / DATA_WIDTH;
    localparam int BEATS   = beats_per_drain(ARRAY_WIDTH, ARRAY_HEIGHT, COUNTER);
    localparam int COL_W   = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;
    localparam int ROW_W   = $clog2(ARRAY_HEIGHT);
    localparam int ELEM_W  = (COUNTER > 1) ? $clog2(COUNTER) : 1;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CRED_W  = $clog2(SLOTS + 1);

    if (((ARRAY_WIDTH * ARRAY_HEIGHT) % COUNTER) != 0) begin : g_bad_geometry
        $error("array size must be a whole number of lane beats");
    end

    drain_state_e              r_state;
    logic [COL_W-1:0]          r_col;
    logic [ROW_W-1:0]          r_row;
    logic [ELEM_W-1:0]         r_elem;
    logic [BEAT_W-1:0]         r_beat;
    logic                      r_fin;
    logic                      r_busy;
    logic                      r_done;
    logic [ARRAY_WIDTH-1:0]    r_sel_n;
    logic [ROW_W-1:0]          r_row_o;

    logic                      w_avail;
    logic [CRED_W-1:0]         w_credits;
    logic                      w_beat_start;
    logic                      w_issue;
    logic                      w_take;
    logic                      w_last;
    logic                      w_col_wrap;
    logic                      w_elem_wrap;
    logic [ARRAY_WIDTH-1:0]    w_sel_n;

    result_credit_counter #(
        .SLOTS (SLOTS)
    ) u_credits (
        .clk     (clk),
        .reset   (reset),
        .take_i  (w_take),
        .give_i  (accepted_i),
        .count_o (w_credits),
        .avail_o (w_avail)
    );

    // Decide whether the element at the drain pointer goes out next cycle
    always_comb begin
        w_beat_start = (r_elem == '0);
        w_issue      = 1'b0;
        case (r_state)
            IDLE:    w_issue = start_i && w_avail;
            ISSUE:   w_issue = !r_fin && (!w_beat_start || w_avail);
            STALL:   w_issue = w_avail;
            default: w_issue = 1'b0;
        endcase
        w_take      = w_issue && w_beat_start;
        w_col_wrap  = (r_col == COL_W'(ARRAY_WIDTH - 1));
        w_elem_wrap = (r_elem == ELEM_W'(COUNTER - 1));
        w_last      = w_elem_wrap && (r_beat == BEAT_W'(BEATS - 1));
        w_sel_n     = '1;
        w_sel_n[r_col] = 1'b0;
    end

    // Drain FSM, pointer advance and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_elem  <= '0;
            r_beat  <= '0;
            r_fin   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sel_n <= '1;
            r_row_o <= '0;
        end else begin
            r_done  <= 1'b0;
            r_sel_n <= w_issue ? w_sel_n : '1;

            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_busy  <= 1'b1;
                        r_fin   <= 1'b0;
                        r_state <= w_avail ? ISSUE : STALL;
                    end
                end
                ISSUE: begin
                    if (r_fin) begin
                        r_state <= FLUSH;
                    end else if (!w_issue) begin
                        r_state <= STALL;
                    end
                end
                STALL: begin
                    if (w_avail) begin
                        r_state <= ISSUE;
                    end
                end
                FLUSH: begin
                    if (w_credits == CRED_W'(SLOTS)) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_issue) begin
                r_row_o <= r_row;
                r_col   <= w_col_wrap ? '0 : r_col + 1'b1;
                if (w_col_wrap) begin
                    r_row <= (r_row == ROW_W'(ARRAY_HEIGHT - 1)) ? '0 : r_row + 1'b1;
                end
                r_elem <= w_elem_wrap ? '0 : r_elem + 1'b1;
                if (w_last) begin
                    r_beat <= '0;
                    r_fin  <= 1'b1;
                end else if (w_elem_wrap) begin
                    r_beat <= r_beat + 1'b1;
                end
            end
        end
    end

    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign array_reset_n_o = r_sel_n;
    assign row_sel_o       = r_row_o;
    assign credits_o       = w_credits;

endmodule
